// File: rtl/osc_pkg.sv
// Shared types and constants for the triggered ADC capture streamer.
package osc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_SEND = 3'd4
  } state_t;

  localparam logic [7:0] FRAME_HDR    = 8'hA5;
  localparam logic       TRIG_RISING  = 1'b0;
  localparam logic       TRIG_FALLING = 1'b1;

  // Crossing test on zero-extended samples; prev/cur compared unsigned.
  function automatic logic trig_hit(input logic [15:0] prev,
                                    input logic [15:0] cur,
                                    input logic [15:0] lvl,
                                    input logic        falling);
    if (falling == TRIG_FALLING)
      return (prev > lvl) && (cur <= lvl);
    else
      return (prev < lvl) && (cur >= lvl);
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer: one write port, registered read port.
module sample_ram #(
  parameter int ADC_WIDTH = 8,
  parameter int DEPTH     = 256,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_waddr,
  input  logic [ADC_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]        i_raddr,
  output logic [ADC_WIDTH-1:0] o_rdata
);

  logic [ADC_WIDTH-1:0] r_mem [DEPTH];
  logic [ADC_WIDTH-1:0] r_rdata;

  // Write port and one-cycle-latency read; no reset so it maps to block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_capture_streamer.sv
// Triggered capture engine: samples the ADC into a circular buffer, waits
// for a trigger, then streams header + frame bytes to the UART.
//
// state | meaning
// IDLE  | not armed, waiting for start
// PRE   | filling the pre-trigger window
// WAIT  | sampling continuously, looking for a trigger
// POST  | capturing the samples after the trigger sample
// SEND  | streaming header and frame bytes to the UART
module adc_capture_streamer
  import osc_pkg::*;
#(
  parameter int ADC_WIDTH    = 8,
  parameter int DEPTH        = 256,
  parameter int PRE_TRIG     = 64,
  parameter int SAMPLE_DIV   = 27,
  parameter int AUTO_TIMEOUT = 100000,
  parameter int BYTE_GAP     = 2600
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [ADC_WIDTH-1:0] i_adc_in,
  input  logic                 i_start,
  input  logic                 i_continuous,
  input  logic                 i_auto_mode,
  input  logic [ADC_WIDTH-1:0] i_trig_level,
  input  logic                 i_trig_falling,
  input  logic                 i_tx_busy,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_send_n,
  output logic                 o_busy,
  output logic                 o_triggered
);

  localparam int AW     = $clog2(DEPTH);
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TO_W   = $clog2(AUTO_TIMEOUT + 1) + 1;
  localparam int GAP_W  = $clog2(BYTE_GAP + 1) + 1;
  localparam int BIDX_W = AW + 2;
  localparam int NBYTES = (ADC_WIDTH > 8) ? 2 * DEPTH : DEPTH;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  state_t r_state, w_next;

  logic [DIV_W-1:0]     r_div;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_start_ptr;
  logic [AW:0]          r_pre_cnt;
  logic [AW:0]          r_post_cnt;
  logic [TO_W-1:0]      r_to_cnt;
  logic [ADC_WIDTH-1:0] r_prev;
  logic                 r_prev_vld;
  logic                 r_triggered;
  logic [GAP_W-1:0]     r_gap;
  logic [BIDX_W-1:0]    r_byte_idx;
  logic                 r_rd_ok;
  logic [7:0]           r_tx_data;
  logic                 r_send_n;

  logic                 w_tick;
  logic                 w_capture;
  logic                 w_edge_hit;
  logic                 w_to_hit;
  logic                 w_trig;
  logic                 w_pre_done;
  logic                 w_post_done;
  logic                 w_issue;
  logic                 w_last;
  logic                 w_enter_pre;
  logic [BIDX_W-1:0]    w_bm1;
  logic [AW-1:0]        w_samp_idx;
  logic [AW-1:0]        w_raddr;
  logic [ADC_WIDTH-1:0] w_rdata;
  logic [15:0]          w_s16;
  logic [7:0]           w_byte;

  assign w_tick      = (r_div == DIV_W'(SAMPLE_DIV - 1));
  assign w_capture   = w_tick && ((r_state == ST_PRE) || (r_state == ST_WAIT) ||
                                  (r_state == ST_POST));
  assign w_edge_hit  = r_prev_vld && trig_hit(16'(r_prev), 16'(i_adc_in),
                                              16'(i_trig_level), i_trig_falling);
  assign w_to_hit    = i_auto_mode && ((32'(r_to_cnt) + 32'd1) >= 32'(AUTO_TIMEOUT));
  assign w_trig      = (r_state == ST_WAIT) && w_tick && (w_edge_hit || w_to_hit);
  assign w_pre_done  = (PRE_TRIG == 0) || (w_tick && (32'(r_pre_cnt) == 32'(PRE_TRIG - 1)));
  assign w_post_done = (POST_N == 0) || (w_tick && (32'(r_post_cnt) == 32'(POST_N - 1)));
  assign w_issue     = (r_state == ST_SEND) && r_rd_ok && !i_tx_busy &&
                       (r_gap >= GAP_W'(BYTE_GAP));
  assign w_last      = w_issue && (32'(r_byte_idx) == 32'(NBYTES));
  assign w_enter_pre = (w_next == ST_PRE) && (r_state != ST_PRE);

  // Byte 0 is the header; wide samples occupy two consecutive bytes.
  assign w_bm1      = r_byte_idx - BIDX_W'(1);
  assign w_samp_idx = (ADC_WIDTH > 8) ? AW'(w_bm1 >> 1) : AW'(w_bm1);
  assign w_raddr    = r_start_ptr + w_samp_idx;
  assign w_s16      = 16'(w_rdata);

  // Select the byte for the current frame position.
  always_comb begin
    w_byte = FRAME_HDR;
    if (r_byte_idx != '0) begin
      if ((ADC_WIDTH > 8) && !w_bm1[0])
        w_byte = w_s16[15:8];
      else
        w_byte = w_s16[7:0];
    end
  end

  sample_ram #(
    .ADC_WIDTH (ADC_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_capture),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_adc_in),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Free-running sample-rate divider.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_div <= '0;
    else if (w_tick)
      r_div <= '0;
    else
      r_div <= r_div + DIV_W'(1);
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start)     w_next = ST_PRE;
      ST_PRE:  if (w_pre_done)  w_next = ST_WAIT;
      ST_WAIT: if (w_trig)      w_next = ST_POST;
      ST_POST: if (w_post_done) w_next = ST_SEND;
      ST_SEND: if (w_last)      w_next = i_continuous ? ST_PRE : ST_IDLE;
      default:                  w_next = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_busy = (r_state != ST_IDLE);
  end

  // Capture counters, trigger bookkeeping and the byte pacer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_start_ptr <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_to_cnt    <= '0;
      r_prev      <= '0;
      r_prev_vld  <= 1'b0;
      r_triggered <= 1'b0;
      r_gap       <= GAP_W'(BYTE_GAP);
      r_byte_idx  <= '0;
      r_rd_ok     <= 1'b0;
      r_tx_data   <= 8'h00;
      r_send_n    <= 1'b1;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_prev   <= i_adc_in;
      end
      if ((r_state == ST_PRE) && w_tick)
        r_pre_cnt <= r_pre_cnt + (AW+1)'(1);
      if ((r_state == ST_POST) && w_tick)
        r_post_cnt <= r_post_cnt + (AW+1)'(1);
      if ((r_state == ST_WAIT) && w_tick) begin
        r_prev_vld <= 1'b1;
        if (32'(r_to_cnt) < 32'(AUTO_TIMEOUT))
          r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_enter_pre) begin
        r_wr_ptr   <= '0;
        r_pre_cnt  <= '0;
        r_post_cnt <= '0;
        r_to_cnt   <= '0;
        r_prev_vld <= 1'b0;
      end
      if (w_trig) begin
        r_triggered <= 1'b1;
        r_start_ptr <= r_wr_ptr - AW'(PRE_TRIG);
      end

      // RAM data is valid one cycle after the read address settles.
      r_send_n <= !w_issue;
      r_rd_ok  <= (r_state == ST_SEND) && !w_issue;
      if (w_issue) begin
        r_tx_data <= w_byte;
        r_gap     <= '0;
      end else if (r_gap < GAP_W'(BYTE_GAP)) begin
        r_gap <= r_gap + GAP_W'(1);
      end
      if ((r_state != ST_SEND) || w_last)
        r_byte_idx <= '0;
      else if (w_issue)
        r_byte_idx <= r_byte_idx + BIDX_W'(1);
      if (w_last)
        r_triggered <= 1'b0;
    end
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_send_n = r_send_n;
  assign o_triggered = r_triggered;

endmodule

// File: tb/tb_adc_capture_streamer.sv
module tb_adc_capture_streamer;

  localparam int GAP = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] adc8 = 8'h00, lvl8 = 8'h40;
  logic       start8 = 0, cont8 = 0, auto8 = 0, fall8 = 0, txb8 = 0;
  logic [7:0] txd8;
  logic       sendn8, busy8, trig8;

  logic [9:0] adc10 = 10'h000, lvl10 = 10'h200;
  logic       start10 = 0, cont10 = 0, auto10 = 0, fall10 = 0, txb10 = 0;
  logic [7:0] txd10;
  logic       sendn10, busy10, trig10;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_strobe = -100000;
  bit ramp_en = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_capture_streamer #(
    .ADC_WIDTH(8), .DEPTH(16), .PRE_TRIG(4), .SAMPLE_DIV(4),
    .AUTO_TIMEOUT(50), .BYTE_GAP(GAP)
  ) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_adc_in(adc8), .i_start(start8),
    .i_continuous(cont8), .i_auto_mode(auto8), .i_trig_level(lvl8),
    .i_trig_falling(fall8), .i_tx_busy(txb8), .o_tx_data(txd8),
    .o_tx_send_n(sendn8), .o_busy(busy8), .o_triggered(trig8)
  );

  adc_capture_streamer #(
    .ADC_WIDTH(10), .DEPTH(16), .PRE_TRIG(4), .SAMPLE_DIV(4),
    .AUTO_TIMEOUT(50), .BYTE_GAP(GAP)
  ) dut10 (
    .i_clk(clk), .i_rst_n(rst_n), .i_adc_in(adc10), .i_start(start10),
    .i_continuous(cont10), .i_auto_mode(auto10), .i_trig_level(lvl10),
    .i_trig_falling(fall10), .i_tx_busy(txb10), .o_tx_data(txd10),
    .o_tx_send_n(sendn10), .o_busy(busy10), .o_triggered(trig10)
  );

  // Ramp source: one step every 4 clocks, matching the sample rate.
  initial begin
    int rdiv;
    rdiv = 0;
    forever begin
      @(negedge clk);
      if (ramp_en) begin
        rdiv++;
        if (rdiv == 4) begin
          rdiv = 0;
          adc8 = adc8 + 8'h01;
        end
      end
    end
  end

  task automatic get_byte(input bit sel, input int max_cyc, output logic [7:0] b,
                          output int gap, output bit tmo);
    tmo = 1; b = 8'h00; gap = 0;
    for (int n = 0; n < max_cyc; n++) begin
      @(posedge clk); #1;
      if ((sel ? sendn10 : sendn8) == 1'b0) begin
        b = sel ? txd10 : txd8;
        gap = cyc - last_strobe;
        last_strobe = cyc;
        tmo = 0;
        break;
      end
    end
  endtask

  task automatic pulse_start8();
    @(negedge clk); start8 = 1;
    @(posedge clk); #1;
    total++;
    if (busy8 !== 1'b1) begin bad++; $display("FAIL busy_after_start got=%b want=1", busy8); end
    @(negedge clk); start8 = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (sendn8 !== 1'b1) begin bad++; $display("FAIL rst_send_n8 got=%b want=1", sendn8); end
    total++; if (txd8 !== 8'h00) begin bad++; $display("FAIL rst_tx_data8 got=%h want=00", txd8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL rst_busy8 got=%b want=0", busy8); end
    total++; if (trig8 !== 1'b0) begin bad++; $display("FAIL rst_trig8 got=%b want=0", trig8); end
    total++; if (sendn10 !== 1'b1) begin bad++; $display("FAIL rst_send_n10 got=%b want=1", sendn10); end
    total++; if (busy10 !== 1'b0) begin bad++; $display("FAIL rst_busy10 got=%b want=0", busy10); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_ramp_rising();
    logic [7:0] b, exp;
    int gap;
    bit tmo;
    @(negedge clk);
    ramp_en = 0; adc8 = 8'h00; lvl8 = 8'h40; fall8 = 0; auto8 = 0; cont8 = 0;
    ramp_en = 1;
    pulse_start8();
    for (int i = 0; i <= 16; i++) begin
      get_byte(0, 3000, b, gap, tmo);
      exp = (i == 0) ? 8'hA5 : 8'h3C + 8'(i - 1);
      total++;
      if (tmo) begin bad++; $display("FAIL ramp_timeout idx=%0d", i); break; end
      if (b !== exp) begin bad++; $display("FAIL ramp_byte idx=%0d got=%h want=%h", i, b, exp); end
      if (i == 0) begin
        total++; if (trig8 !== 1'b1) begin bad++; $display("FAIL ramp_triggered got=%b want=1", trig8); end
        @(posedge clk); #1;
        total++; if (sendn8 !== 1'b1) begin bad++; $display("FAIL strobe_width send_n=%b want=1", sendn8); end
      end else begin
        total++; if (gap < GAP) begin bad++; $display("FAIL ramp_gap idx=%0d got=%0d want>=%0d", i, gap, GAP); end
      end
    end
    repeat (3) @(posedge clk); #1;
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL ramp_end_busy got=%b want=0", busy8); end
    total++; if (trig8 !== 1'b0) begin bad++; $display("FAIL ramp_end_trig got=%b want=0", trig8); end
  endtask

  task automatic test_auto_trigger();
    logic [7:0] b, exp;
    int gap, n;
    bit tmo, hit;
    @(negedge clk);
    ramp_en = 0; adc8 = 8'h10; auto8 = 1; start8 = 1;
    @(posedge clk);
    @(negedge clk); start8 = 0;
    n = 0; hit = 0;
    while (n < 400 && !hit) begin
      @(posedge clk); #1; n++;
      if (trig8) hit = 1;
    end
    total++;
    if (!hit || n < 213 || n > 216)
      begin bad++; $display("FAIL auto_latency got=%0d hit=%b want=213..216", n, hit); end
    for (int i = 0; i <= 16; i++) begin
      get_byte(0, 1000, b, gap, tmo);
      exp = (i == 0) ? 8'hA5 : 8'h10;
      total++;
      if (tmo) begin bad++; $display("FAIL auto_timeout idx=%0d", i); break; end
      if (b !== exp) begin bad++; $display("FAIL auto_byte idx=%0d got=%h want=%h", i, b, exp); end
    end
    auto8 = 0;
  endtask

  task automatic test_no_auto_and_post_start();
    logic [7:0] b;
    int gap, n;
    bit tmo, saw_trig, saw_strobe, hit;
    @(negedge clk);
    adc8 = 8'h10; auto8 = 0;
    pulse_start8();
    saw_trig = 0; saw_strobe = 0;
    repeat (2000) begin
      @(posedge clk); #1;
      if (trig8) saw_trig = 1;
      if (!sendn8) saw_strobe = 1;
    end
    total++; if (saw_trig) begin bad++; $display("FAIL noauto_trig got=1 want=0"); end
    total++; if (saw_strobe) begin bad++; $display("FAIL noauto_strobe got=1 want=0"); end
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL noauto_busy got=%b want=1", busy8); end
    @(negedge clk); auto8 = 1;
    hit = 0; n = 0;
    while (n < 20 && !hit) begin
      @(posedge clk); #1; n++;
      if (trig8) hit = 1;
    end
    total++; if (!hit) begin bad++; $display("FAIL late_auto_trig got=0 want=1"); end
    for (int k = 0; k < 3; k++) begin
      repeat (5) @(negedge clk);
      start8 = 1;
      @(negedge clk); start8 = 0;
    end
    auto8 = 0;
    for (int i = 0; i <= 16; i++) begin
      get_byte(0, 1000, b, gap, tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL post_frame_timeout idx=%0d", i); break; end
      if (b !== ((i == 0) ? 8'hA5 : 8'h10))
        begin bad++; $display("FAIL post_frame_byte idx=%0d got=%h", i, b); end
    end
    get_byte(0, 400, b, gap, tmo);
    total++; if (!tmo) begin bad++; $display("FAIL post_start_rearm extra byte=%h want none", b); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL post_start_busy got=%b want=0", busy8); end
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] b;
    int gap;
    bit tmo, saw;
    @(negedge clk);
    ramp_en = 0; adc8 = 8'h00; lvl8 = 8'h40; fall8 = 0; auto8 = 0;
    ramp_en = 1;
    pulse_start8();
    for (int i = 0; i < 4; i++) begin
      get_byte(0, 3000, b, gap, tmo);
      total++;
      if (tmo) begin bad++; $display("FAIL rstsend_timeout idx=%0d", i); break; end
      if (b !== ((i == 0) ? 8'hA5 : 8'h3C + 8'(i - 1)))
        begin bad++; $display("FAIL rstsend_byte idx=%0d got=%h", i, b); end
    end
    @(negedge clk); rst_n = 0;
    @(posedge clk); #1;
    total++; if (sendn8 !== 1'b1) begin bad++; $display("FAIL rstsend_send_n got=%b want=1", sendn8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL rstsend_busy got=%b want=0", busy8); end
    total++; if (trig8 !== 1'b0) begin bad++; $display("FAIL rstsend_trig got=%b want=0", trig8); end
    @(negedge clk); rst_n = 1;
    saw = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (!sendn8 || busy8) saw = 1;
    end
    total++; if (saw) begin bad++; $display("FAIL rstsend_quiet got=activity want=none"); end
  endtask

  task automatic test_continuous_falling();
    logic [7:0] b, exp;
    int gap;
    bit tmo;
    @(negedge clk);
    ramp_en = 0; adc8 = 8'h10; lvl8 = 8'h80; fall8 = 1; cont8 = 1; auto8 = 0;
    ramp_en = 1;
    pulse_start8();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i <= 16; i++) begin
        get_byte(0, 3000, b, gap, tmo);
        exp = (i == 0) ? 8'hA5 : 8'hFC + 8'(i - 1);
        total++;
        if (tmo) begin bad++; $display("FAIL cont_timeout frame=%0d idx=%0d", f, i); break; end
        if (b !== exp) begin bad++; $display("FAIL cont_byte frame=%0d idx=%0d got=%h want=%h", f, i, b, exp); end
        if (f == 1 && i == 0) begin
          total++; if (gap < GAP) begin bad++; $display("FAIL cont_hdr_gap got=%0d want>=%0d", gap, GAP); end
        end
      end
      if (f == 0) begin
        repeat (3) @(posedge clk); #1;
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL cont_rearm_busy got=%b want=1", busy8); end
        @(negedge clk); cont8 = 0;
      end
    end
    repeat (3) @(posedge clk); #1;
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL cont_stop_busy got=%b want=0", busy8); end
    ramp_en = 0; fall8 = 0;
  endtask

  task automatic test_wide_busy();
    logic [7:0] b, exp;
    int gap;
    bit tmo, saw;
    @(negedge clk);
    adc10 = 10'h3FF; auto10 = 1; txb10 = 1; start10 = 1;
    @(negedge clk); start10 = 0;
    saw = 0;
    repeat (5000) begin
      @(posedge clk); #1;
      if (!sendn10) saw = 1;
    end
    total++; if (saw) begin bad++; $display("FAIL wide_strobe_while_busy got=1 want=0"); end
    total++; if (trig10 !== 1'b1) begin bad++; $display("FAIL wide_triggered got=%b want=1", trig10); end
    @(negedge clk); txb10 = 0;
    for (int i = 0; i <= 32; i++) begin
      get_byte(1, (i == 0) ? 5 : 200, b, gap, tmo);
      exp = (i == 0) ? 8'hA5 : ((i % 2) == 1) ? 8'h03 : 8'hFF;
      total++;
      if (tmo) begin bad++; $display("FAIL wide_timeout idx=%0d", i); break; end
      if (b !== exp) begin bad++; $display("FAIL wide_byte idx=%0d got=%h want=%h", i, b, exp); end
    end
    repeat (3) @(posedge clk); #1;
    total++; if (busy10 !== 1'b0) begin bad++; $display("FAIL wide_end_busy got=%b want=0", busy10); end
  endtask

  initial begin
    test_reset();
    test_ramp_rising();
    test_auto_trigger();
    test_no_auto_and_post_start();
    test_reset_mid_send();
    test_continuous_falling();
    test_wide_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
